// File: rtl/countdown_timer.sv
// Prescaled down-counter timer with a valid/ready load port, one-shot or periodic
// reload, a one-cycle expiry pulse and a saturating expiry counter.
module countdown_timer #(
  parameter int WIDTH  = 8,
  parameter int ECNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [WIDTH-1:0]  load_period,
  input  logic [WIDTH-1:0]  load_prescale,
  input  logic              load_periodic,
  input  logic              start,
  input  logic              stop,
  output logic              busy,
  output logic [WIDTH-1:0]  count,
  output logic              expire,
  output logic [ECNT_W-1:0] expire_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOADED  = 2'd1,
    RUNNING = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t              r_state;
  logic [WIDTH-1:0]    r_count;
  logic [WIDTH-1:0]    r_presc;
  logic [WIDTH-1:0]    r_period;
  logic [WIDTH-1:0]    r_prescale;
  logic                r_periodic;
  logic                r_expire;
  logic [ECNT_W-1:0]   r_ecnt;

  state_t              w_state_next;
  logic [WIDTH-1:0]    w_count_next;
  logic [WIDTH-1:0]    w_presc_next;
  logic [WIDTH-1:0]    w_period_next;
  logic [WIDTH-1:0]    w_prescale_next;
  logic                w_periodic_next;
  logic                w_expire_next;
  logic [ECNT_W-1:0]   w_ecnt_next;
  logic                w_tick;

  assign w_tick = (r_presc == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_presc    <= '0;
      r_period   <= '0;
      r_prescale <= '0;
      r_periodic <= 1'b0;
      r_expire   <= 1'b0;
      r_ecnt     <= '0;
    end else begin
      r_state    <= w_state_next;
      r_count    <= w_count_next;
      r_presc    <= w_presc_next;
      r_period   <= w_period_next;
      r_prescale <= w_prescale_next;
      r_periodic <= w_periodic_next;
      r_expire   <= w_expire_next;
      r_ecnt     <= w_ecnt_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_count_next    = r_count;
    w_presc_next    = r_presc;
    w_period_next   = r_period;
    w_prescale_next = r_prescale;
    w_periodic_next = r_periodic;
    w_expire_next   = 1'b0;
    w_ecnt_next     = r_ecnt;

    case (r_state)
      IDLE, LOADED, EXPIRED: begin
        // A load on the same edge as start takes precedence.
        if (load_valid) begin
          w_period_next   = load_period;
          w_prescale_next = load_prescale;
          w_periodic_next = load_periodic;
          w_count_next    = load_period;
          w_ecnt_next     = '0;
          w_state_next    = LOADED;
        end else if (start && (r_state != IDLE)) begin
          w_count_next = r_period;
          w_presc_next = r_prescale;
          w_state_next = RUNNING;
        end
      end

      RUNNING: begin
        if (stop) begin
          w_count_next = r_period;
          w_state_next = LOADED;
        end else begin
          w_presc_next = w_tick ? r_prescale : (r_presc - 1'b1);
          if (w_tick) begin
            if (r_count != '0) begin
              w_count_next = r_count - 1'b1;
            end else begin
              w_expire_next = 1'b1;
              if (r_ecnt != '1) begin
                w_ecnt_next = r_ecnt + 1'b1;
              end
              if (r_periodic) begin
                w_count_next = r_period;
              end else begin
                w_state_next = EXPIRED;
              end
            end
          end
        end
      end

      default: w_state_next = IDLE;
    endcase
  end

  assign load_ready   = (r_state != RUNNING);
  assign busy         = (r_state == RUNNING);
  assign count        = r_count;
  assign expire       = r_expire;
  assign expire_count = r_ecnt;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer; inputs change and outputs
// are sampled on the falling clock edge.
module tb_countdown_timer;

  logic       clk;
  logic       rst_n;
  logic       load_valid;
  logic       load_ready;
  logic [7:0] load_period;
  logic [7:0] load_prescale;
  logic       load_periodic;
  logic       start;
  logic       stop;
  logic       busy;
  logic [7:0] count;
  logic       expire;
  logic [7:0] expire_count;

  int checks = 0;
  int errors = 0;
  int n;
  int hits;

  countdown_timer #(.WIDTH(8), .ECNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_period  (load_period),
    .load_prescale(load_prescale),
    .load_periodic(load_periodic),
    .start        (start),
    .stop         (stop),
    .busy         (busy),
    .count        (count),
    .expire       (expire),
    .expire_count (expire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Counts falling edges until expire is seen, bounded by limit.
  task automatic wait_expire(output int cnt, input int limit);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!expire && cnt < limit);
  endtask

  task automatic do_load(input logic [7:0] p, input logic [7:0] s, input logic per);
    load_valid = 1'b1; load_period = p; load_prescale = s; load_periodic = per;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; load_valid = 1'b0; load_period = '0; load_prescale = '0;
    load_periodic = 1'b0; start = 1'b0; stop = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", load_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_count", count, 0);
    chk("rst_expire", expire, 0);
    chk("rst_ecnt", expire_count, 0);
    rst_n = 1'b1;
    @(negedge clk);

    do_start();
    chk("idle_start_ignored", busy, 0);

    // One-shot P=3,S=0: N=4
    do_load(8'd3, 8'd0, 1'b0);
    chk("t1_load_count", count, 3);
    chk("t1_load_ready", load_ready, 1);
    do_start();
    chk("t1_busy", busy, 1);
    wait_expire(n, 20);
    chk("t1_latency", n, 4);
    @(negedge clk);
    chk("t1_pulse_single", expire, 0);
    chk("t1_busy_done", busy, 0);
    chk("t1_count0", count, 0);
    chk("t1_ecnt", expire_count, 1);
    chk("t1_ready", load_ready, 1);
    $display("txn oneshot P=3 S=0 latency=%0d ecnt=%0d", n, expire_count);

    // Periodic P=1,S=2: N=6, loads ignored while running
    do_load(8'd1, 8'd2, 1'b1);
    chk("t2_ecnt_cleared", expire_count, 0);
    do_start();
    wait_expire(n, 20);
    chk("t2_lat1", n, 6);
    load_valid = 1'b1; load_period = 8'd7; load_prescale = 8'd0; load_periodic = 1'b0;
    chk("t2_ready_low", load_ready, 0);
    wait_expire(n, 20);
    chk("t2_lat2", n, 6);
    chk("t2_count_reload", count, 1);
    chk("t2_busy", busy, 1);
    load_valid = 1'b0;
    wait_expire(n, 20);
    chk("t2_lat3", n, 6);
    chk("t2_ecnt", expire_count, 3);
    $display("txn periodic P=1 S=2 third_latency=%0d ecnt=%0d", n, expire_count);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("t2_stop_busy", busy, 0);
    chk("t2_stop_count", count, 1);

    // Long run P=254,S=127: N=32640
    do_load(8'd254, 8'd127, 1'b0);
    chk("t3_ecnt_cleared", expire_count, 0);
    do_start();
    repeat (127) @(negedge clk);
    chk("t3_count_hold", count, 254);
    @(negedge clk);
    chk("t3_count_dec", count, 253);
    wait_expire(n, 32600);
    chk("t3_latency_rest", n, 32640 - 128);
    chk("t3_ecnt", expire_count, 1);
    @(negedge clk);
    chk("t3_busy_done", busy, 0);
    $display("txn long P=254 S=127 latency=%0d", n + 128);

    // Stop on the edge of the final tick: P=2,S=0
    do_load(8'd2, 8'd0, 1'b0);
    do_start();
    repeat (2) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("t4_no_expire", expire, 0);
    chk("t4_busy", busy, 0);
    chk("t4_count", count, 2);
    chk("t4_ecnt", expire_count, 0);
    @(negedge clk);
    chk("t4_no_expire_late", expire, 0);
    $display("txn stop-at-final-tick count=%0d ecnt=%0d", count, expire_count);

    // Periodic P=0,S=0: expire every cycle, counter saturates
    do_load(8'd0, 8'd0, 1'b1);
    do_start();
    hits = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (expire) hits++;
    end
    chk("t5_every_cycle", hits, 300);
    chk("t5_saturate", expire_count, 255);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("t5_stop_keeps_ecnt", expire_count, 255);
    do_load(8'd5, 8'd0, 1'b0);
    chk("t5_load_clears", expire_count, 0);
    chk("t5_load_count", count, 5);
    $display("txn periodic P=0 S=0 hits=%0d", hits);

    // Load and start on the same edge: load wins
    load_valid = 1'b1; load_period = 8'd9; start = 1'b1;
    @(negedge clk);
    load_valid = 1'b0; start = 1'b0;
    chk("t6_load_wins_busy", busy, 0);
    chk("t6_load_wins_count", count, 9);

    // Start and stop together in LOADED: start wins
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk("t6_start_wins", busy, 1);
    $display("txn priority load/start/stop busy=%0d count=%0d", busy, count);

    // Asynchronous reset mid-run
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_async_busy", busy, 0);
    chk("t7_async_count", count, 0);
    chk("t7_async_expire", expire, 0);
    chk("t7_async_ready", load_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t7_post_busy", busy, 0);
    chk("t7_post_count", count, 0);
    chk("t7_post_ecnt", expire_count, 0);
    chk("t7_post_expire", expire, 0);
    $display("txn async-reset busy=%0d count=%0d", busy, count);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
Programmable prescaled down-counter timer for the amlib timers test group. It sits directly downstream of the 8-bit operand source that drives the x/y pair under formal test. It accepts a period/prescale pair over a valid/ready load port and counts down after a start command. It emits a one-cycle expiry pulse and a saturating expiry count, in one-shot or periodic mode.

Parameters:
WIDTH, 8, width of period, prescale and remaining-count values
ECNT_W, 8, width of saturating expiry counter

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
load_valid  input  1  load request
load_ready  output  1  block can accept a load this cycle
load_period  input  WIDTH  period value P (drives x in the formal harness)
load_prescale  input  WIDTH  prescale value S (drives y in the formal harness)
load_periodic  input  1  1 = auto-reload on expiry, 0 = one-shot
start  input  1  start/restart countdown
stop  input  1  abort countdown
busy  output  1  high while in RUNNING
count  output  WIDTH  remaining ticks
expire  output  1  one-cycle expiry pulse
expire_count  output  ECNT_W  saturating number of expiries since last load

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; count=0; prescaler=0; stored P/S/periodic=0.
  - expire=0, expire_count=0, busy=0, load_ready=1.
  - Reset mid-count aborts immediately with no expire pulse.
- States: IDLE, LOADED, RUNNING, EXPIRED. All outputs are registered except load_ready and busy, which decode state.
- load_ready=1 in IDLE/LOADED/EXPIRED and 0 in RUNNING.
- Load accept: load_valid && load_ready on an edge. Effects:
  - store P, S and periodic;
  - set count=P;
  - clear expire_count;
  - next state=LOADED.
  - A load in LOADED overwrites the stored values.
- start:
  - In LOADED or EXPIRED: next state=RUNNING, count=P, prescaler=S.
  - Ignored in IDLE and RUNNING.
  - If load and start are sampled on the same edge, the load wins and start is ignored.
- RUNNING, each cycle:
  - If prescaler==0: reload prescaler=S and generate a tick. Otherwise decrement the prescaler.
  - On a tick with count>0: count decrements.
  - On a tick with count==0: expire=1 for the next cycle only, and expire_count increments, saturating at 2^ECNT_W-1.
    - Periodic: count=P, stay RUNNING.
    - One-shot: go to EXPIRED, count holds 0.
- Latency: the first expire is high exactly N=(P+1)*(S+1) cycles after the start-accept edge. Periodic expiries follow every N cycles. P=0,S=0 gives expire every cycle (N=1).
- stop in RUNNING:
  - next state=LOADED, count=P, no expire.
  - stop has priority over an expiry tick on the same edge.
  - stop is ignored outside RUNNING.
- start and stop on the same edge in LOADED: start wins (stop is ignored outside RUNNING).
- Arithmetic: counters are unsigned, modulo-free. Decrement never occurs at 0, so there is no wrap-around. P=S=255 gives N=65536.
- expire never asserts in IDLE, LOADED or EXPIRED except the single cycle following the final tick.

Test Plan:
- Reset with rst_n=0 mid-RUNNING -> asynchronous clear; expire=0, busy=0, count=0, load_ready=1 while rst_n low and after release.
- Load P=3,S=0, one-shot, then start -> busy=1; expire high exactly 4 cycles after the start edge, single cycle; state EXPIRED, count=0, expire_count=1.
- Load P=1,S=2, periodic, then start -> expire at cycles 6, 12, 18 after start; busy stays 1; load_valid ignored (load_ready=0) while running.
- Load P=254 (0xFE), S=127 (0x7F), then start -> first expire at 255*128=32640 cycles; count decrements once per 128 cycles.
- Start then stop asserted on the edge the final tick would occur (P=2,S=0, stop at cycle 3) -> no expire, state LOADED, count=2, expire_count=0.
- Periodic P=0,S=0 running 300 cycles -> expire every cycle, expire_count saturates at 255; new load clears it to 0.
